// File: rtl/net_echo_responder.sv
// Ethernet echo responder: swaps destination and source MAC of each
// received frame and sends it back, keeping frame statistics.
module net_echo_responder #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             net_rx_tvalid,
  output logic             net_rx_tready,
  input  logic [63:0]      net_rx_tdata,
  input  logic [7:0]       net_rx_tkeep,
  input  logic             net_rx_tlast,
  output logic             net_tx_tvalid,
  input  logic             net_tx_tready,
  output logic [63:0]      net_tx_tdata,
  output logic [7:0]       net_tx_tkeep,
  output logic             net_tx_tlast,
  output logic [CNT_W-1:0] frames_rx,
  output logic [CNT_W-1:0] frames_tx,
  output logic [CNT_W-1:0] frames_dropped
);

  typedef enum logic [2:0] {
    IDLE, HOLD0, STREAM, FLUSH, DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [63:0]      hold_q;
  logic [7:0]       hold_keep_q;
  logic             tx_valid_q, tx_last_q;
  logic [63:0]      tx_data_q;
  logic [7:0]       tx_keep_q;
  logic [CNT_W-1:0] rx_cnt_q, tx_cnt_q, drop_cnt_q;

  logic        can_acc, rx_ready_c, rx_fire, short_last;
  logic        cap_first, emit_first, emit_mid, emit_last, drop;
  logic [63:0] out0_w, out1_w;

  assign can_acc    = !tx_valid_q || net_tx_tready;
  assign rx_fire    = net_rx_tvalid && net_rx_tready;
  assign short_last = net_rx_tlast && (net_rx_tkeep[3:0] != 4'hF);

  // first two beats re-arranged so the two MAC addresses trade places
  assign out0_w = {hold_q[15:0], net_rx_tdata[31:0], hold_q[63:48]};
  assign out1_w = {net_rx_tdata[63:32], hold_q[47:16]};

  assign cap_first  = (state_q == IDLE) && rx_fire
                      && !net_rx_tlast && enable;
  assign emit_first = (state_q == HOLD0) && rx_fire && !short_last;
  assign emit_mid   = (state_q == STREAM) && rx_fire;
  assign emit_last  = (state_q == FLUSH) && can_acc;
  assign drop       = rx_fire && (
                        ((state_q == IDLE)  && net_rx_tlast) ||
                        ((state_q == HOLD0) && short_last)   ||
                        ((state_q == DRAIN) && net_rx_tlast));

  // state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:
        if (rx_fire && !net_rx_tlast)
          state_d = enable ? HOLD0 : DRAIN;
      DRAIN:
        if (rx_fire && net_rx_tlast) state_d = IDLE;
      HOLD0:
        if (rx_fire) begin
          if (short_last)        state_d = IDLE;
          else if (net_rx_tlast) state_d = FLUSH;
          else                   state_d = STREAM;
        end
      STREAM:
        if (rx_fire && net_rx_tlast) state_d = FLUSH;
      FLUSH:
        if (can_acc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rx ready: always open when idle/draining, back-pressured when emitting
  always_comb begin
    rx_ready_c = 1'b0;
    case (state_q)
      IDLE, DRAIN:   rx_ready_c = 1'b1;
      HOLD0, STREAM: rx_ready_c = can_acc;
      default:       rx_ready_c = 1'b0;
    endcase
    net_rx_tready = rx_ready_c && !reset;
  end

  // hold register, output register and statistics
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q      <= '0;
      hold_keep_q <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_keep_q   <= '0;
      tx_last_q   <= 1'b0;
      rx_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (tx_valid_q && net_tx_tready) tx_valid_q <= 1'b0;
      if (cap_first) hold_q <= net_rx_tdata;
      if (emit_first) begin
        tx_valid_q  <= 1'b1;
        tx_data_q   <= out0_w;
        tx_keep_q   <= 8'hFF;
        tx_last_q   <= 1'b0;
        hold_q      <= out1_w;
        hold_keep_q <= net_rx_tkeep;
      end
      if (emit_mid) begin
        tx_valid_q  <= 1'b1;
        tx_data_q   <= hold_q;
        tx_keep_q   <= hold_keep_q;
        tx_last_q   <= 1'b0;
        hold_q      <= net_rx_tdata;
        hold_keep_q <= net_rx_tkeep;
      end
      if (emit_last) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= hold_q;
        tx_keep_q  <= hold_keep_q;
        tx_last_q  <= 1'b1;
      end
      if (rx_fire && net_rx_tlast) rx_cnt_q <= rx_cnt_q + 1'b1;
      if (tx_valid_q && net_tx_tready && tx_last_q)
        tx_cnt_q <= tx_cnt_q + 1'b1;
      if (drop) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign net_tx_tvalid  = tx_valid_q;
  assign net_tx_tdata   = tx_data_q;
  assign net_tx_tkeep   = tx_keep_q;
  assign net_tx_tlast   = tx_last_q;
  assign frames_rx      = rx_cnt_q;
  assign frames_tx      = tx_cnt_q;
  assign frames_dropped = drop_cnt_q;

endmodule

// File: tb/tb_net_echo_responder.sv
// Bench for net_echo_responder: directed scenarios plus random frames
// checked against a byte-level model of the MAC swap.
module tb_net_echo_responder;
  localparam int CNT_W = 32;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b1;
  logic             rx_valid = 1'b0;
  logic             rx_ready;
  logic [63:0]      rx_data = '0;
  logic [7:0]       rx_keep = '0;
  logic             rx_last = 1'b0;
  logic             tx_valid;
  logic             tx_ready = 1'b1;
  logic [63:0]      tx_data;
  logic [7:0]       tx_keep;
  logic             tx_last;
  logic [CNT_W-1:0] c_rx, c_tx, c_drop;

  int nchk = 0;
  int nerr = 0;
  int rdy_mode = 0;

  beat_t fr_q[$];
  beat_t exp_q[$];
  beat_t got_q[$];
  beat_t lg_q[$];
  int unsigned m_rx = 0, m_tx = 0, m_drop = 0;

  bit    prev_stall = 0;
  beat_t prev;

  net_echo_responder #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .net_rx_tvalid(rx_valid), .net_rx_tready(rx_ready),
    .net_rx_tdata(rx_data), .net_rx_tkeep(rx_keep),
    .net_rx_tlast(rx_last),
    .net_tx_tvalid(tx_valid), .net_tx_tready(tx_ready),
    .net_tx_tdata(tx_data), .net_tx_tkeep(tx_keep),
    .net_tx_tlast(tx_last),
    .frames_rx(c_rx), .frames_tx(c_tx), .frames_dropped(c_drop)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // tx back-pressure pattern
  always @(negedge clock) begin
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // tx monitor: collects handshakes, checks stability under stall
  always @(negedge clock) begin
    #4;
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(tx_valid), 64'd1);
        chk("stall_data", tx_data, prev.d);
        chk("stall_keep", 64'(tx_keep), 64'(prev.k));
        chk("stall_last", 64'(tx_last), 64'(prev.l));
      end
      if (tx_valid && tx_ready)
        got_q.push_back('{d: tx_data, k: tx_keep, l: tx_last});
      prev_stall = tx_valid && !tx_ready;
      prev = '{d: tx_data, k: tx_keep, l: tx_last};
    end
  end

  task automatic samp();
    @(negedge clock);
    #4;
  endtask

  // drive fr_q beats 0..nsend-1 with optional random idle gaps
  task automatic send_frame(input int nsend, input bit gaps);
    bit acc;
    for (int i = 0; i < nsend; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(negedge clock);
        rx_valid = 1'b0;
      end
      @(negedge clock);
      rx_valid = 1'b1;
      rx_data  = fr_q[i].d;
      rx_keep  = fr_q[i].k;
      rx_last  = fr_q[i].l;
      acc = 0;
      for (int c = 0; c < 300 && !acc; c++) begin
        #4;
        acc = rx_ready;
        @(posedge clock);
        if (!acc) @(negedge clock);
      end
      if (!acc) chk("rx_accept_timeout", 64'd0, 64'd1);
    end
    @(negedge clock);
    rx_valid = 1'b0;
    rx_last  = 1'b0;
  endtask

  // reference: byte-level MAC swap, drop rules, counter bookkeeping
  task automatic build_expected(input bit en);
    logic [7:0] by[$];
    logic [7:0] t;
    int n;
    beat_t b;
    n = fr_q.size();
    exp_q.delete();
    m_rx++;
    if (n < 2 || !en || (n == 2 && fr_q[1].k[3:0] != 4'hF)) begin
      m_drop++;
      return;
    end
    m_tx++;
    foreach (fr_q[i])
      for (int j = 0; j < 8; j++) by.push_back(fr_q[i].d[8*j +: 8]);
    for (int j = 0; j < 6; j++) begin
      t = by[j];
      by[j] = by[j+6];
      by[j+6] = t;
    end
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 8; j++) b.d[8*j +: 8] = by[8*i + j];
      b.k = (i == 0) ? 8'hFF : fr_q[i].k;
      b.l = (i == n - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic check_frame(input string tag);
    for (int c = 0; c < 400 && got_q.size() < exp_q.size(); c++)
      @(posedge clock);
    repeat (4) @(posedge clock);
    #1;
    chk({tag, "_nbeats"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_d%0d", tag, i), got_q[i].d, exp_q[i].d);
      chk($sformatf("%s_k%0d", tag, i), 64'(got_q[i].k), 64'(exp_q[i].k));
      chk($sformatf("%s_l%0d", tag, i), 64'(got_q[i].l), 64'(exp_q[i].l));
    end
    chk({tag, "_frames_rx"}, 64'(c_rx), 64'(m_rx));
    chk({tag, "_frames_tx"}, 64'(c_tx), 64'(m_tx));
    chk({tag, "_frames_dropped"}, 64'(c_drop), 64'(m_drop));
    lg_q = got_q;
    got_q.delete();
  endtask

  task automatic rand_frame(input int len, input logic [7:0] lastk);
    beat_t b;
    fr_q.delete();
    for (int i = 0; i < len; i++) begin
      b.d = {$urandom, $urandom};
      b.k = (i == len - 1) ? lastk : 8'($urandom);
      b.l = (i == len - 1);
      fr_q.push_back(b);
    end
  endtask

  task automatic run_frame(input string tag, input bit en, input bit gaps);
    enable = en;
    build_expected(en);
    send_frame(fr_q.size(), gaps);
    check_frame(tag);
  endtask

  initial begin
    logic [7:0] lk;
    repeat (3) @(posedge clock);
    samp();
    chk("rst_rx_ready", 64'(rx_ready), 64'd0);
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_data", tx_data, 64'd0);
    chk("rst_tx_keep", 64'(tx_keep), 64'd0);
    chk("rst_tx_last", 64'(tx_last), 64'd0);
    chk("rst_cnt_rx", 64'(c_rx), 64'd0);
    chk("rst_cnt_tx", 64'(c_tx), 64'd0);
    chk("rst_cnt_drop", 64'(c_drop), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #4;
    chk("post_rst_rx_ready", 64'(rx_ready), 64'd1);

    // known 3-beat frame
    fr_q.delete();
    fr_q.push_back('{d: 64'h0807060504030201, k: 8'hFF, l: 1'b0});
    fr_q.push_back('{d: 64'h100F0E0D0C0B0A09, k: 8'hFF, l: 1'b0});
    fr_q.push_back('{d: 64'h1817161514131211, k: 8'h0F, l: 1'b1});
    run_frame("f3", 1'b1, 1'b0);
    if (lg_q.size() == 3) begin
      chk("f3_const0", lg_q[0].d, 64'h02010C0B0A090807);
      chk("f3_const1", lg_q[1].d, 64'h100F0E0D06050403);
      chk("f3_const2", lg_q[2].d, 64'h1817161514131211);
      chk("f3_constk2", 64'(lg_q[2].k), 64'h0F);
      chk("f3_constl2", 64'(lg_q[2].l), 64'd1);
    end

    // runt
    rand_frame(1, 8'hFF);
    run_frame("runt", 1'b1, 1'b0);

    // short second beat
    rand_frame(2, 8'h03);
    run_frame("short2", 1'b1, 1'b0);

    // 2-beat frame with exactly 4 valid final bytes
    rand_frame(2, 8'h0F);
    run_frame("min2", 1'b1, 1'b0);

    // 10 beats under toggling back-pressure
    rdy_mode = 1;
    rand_frame(10, 8'hFF);
    run_frame("toggle10", 1'b1, 1'b0);
    rdy_mode = 0;

    // disabled frame then enabled frame
    rand_frame(4, 8'hFF);
    run_frame("dis4", 1'b0, 1'b0);
    rand_frame(4, 8'h3F);
    run_frame("en4", 1'b1, 1'b0);

    // reset in the middle of a frame
    rand_frame(5, 8'hFF);
    enable = 1'b1;
    send_frame(2, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    samp();
    chk("midrst_tx_valid", 64'(tx_valid), 64'd0);
    chk("midrst_rx_ready", 64'(rx_ready), 64'd0);
    chk("midrst_cnt_rx", 64'(c_rx), 64'd0);
    chk("midrst_cnt_tx", 64'(c_tx), 64'd0);
    chk("midrst_cnt_drop", 64'(c_drop), 64'd0);
    got_q.delete();
    m_rx = 0;
    m_tx = 0;
    m_drop = 0;
    @(negedge clock);
    reset = 1'b0;
    #4;
    chk("midrst_rx_ready_after", 64'(rx_ready), 64'd1);
    repeat (3) @(posedge clock);
    #1;
    chk("midrst_no_residual", 64'(got_q.size()), 64'd0);
    rand_frame(5, 8'hFF);
    run_frame("after_rst", 1'b1, 1'b0);

    // random frames
    for (int f = 0; f < 24; f++) begin
      rdy_mode = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0:       lk = 8'hFF;
        1:       lk = 8'h0F;
        2:       lk = 8'h03;
        default: lk = 8'($urandom_range(1, 255));
      endcase
      rand_frame($urandom_range(1, 8), lk);
      run_frame($sformatf("rnd%0d", f), $urandom_range(0, 3) != 0, 1'b1);
    end
    rdy_mode = 0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
